// File: rtl/commfifo_apb_master.sv
// commfifo_apb_master: polled APB requester moving tx/rx bytes to the commfifo completer; define COMMFIFO_MASTER_TIMEOUT_EN for an ACCESS wait-state timeout
module commfifo_apb_master #(
  parameter int POLL_GAP = 4
`ifdef COMMFIFO_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  output logic        PSEL,
  output logic [9:0]  PADDR,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic        i_tx_valid,
  input  logic [7:0]  i_tx_data,
  output logic        o_tx_ready,
  output logic        o_rx_valid,
  output logic [7:0]  o_rx_data,
  input  logic        i_rx_ready,
  output logic        o_err,
  input  logic        i_err_clr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;
  logic [9:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [7:0] tx_data_q, tx_data_d, rx_data_q, rx_data_d, tx_gap_q, tx_gap_d, rx_gap_q, rx_gap_d;
  logic pwrite_q, pwrite_d, op_tx_q, op_tx_d, last_tx_q, last_tx_d;
  logic tx_full_q, tx_full_d, rx_valid_q, rx_valid_d, err_q, err_d;
  logic tx_acc, rx_rel, tx_pend, rx_pend, sel_tx, fail, err_set, abort;
  logic unused;
  assign unused = ^PRDATA[31:8];
`ifdef COMMFIFO_MASTER_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;
  assign to_cnt_d = (state_q == ACCESS && !PREADY) ? to_cnt_q + 8'd1 : 8'd0;
  assign abort = state_q == ACCESS && !PREADY && to_cnt_q == 8'(TIMEOUT - 1);
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) to_cnt_q <= 8'd0;
    else to_cnt_q <= to_cnt_d;
`else
  assign abort = 1'b0;
`endif
  assign PSEL = state_q != IDLE;
  assign PENABLE = state_q == ACCESS;
  assign PADDR = paddr_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = pwdata_q;
  assign o_tx_ready = ~tx_full_q;
  assign o_rx_valid = rx_valid_q;
  assign o_rx_data = rx_data_q;
  assign o_err = err_q;
  always_comb begin
    state_d = state_q;
    paddr_d = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    op_tx_d = op_tx_q;
    last_tx_d = last_tx_q;
    rx_data_d = rx_data_q;
    err_set = 1'b0;
    tx_acc = i_tx_valid & ~tx_full_q;
    rx_rel = rx_valid_q & i_rx_ready;
    tx_full_d = tx_full_q | tx_acc;
    tx_data_d = tx_acc ? i_tx_data : tx_data_q;
    rx_valid_d = rx_valid_q & ~rx_rel;
    tx_gap_d = tx_gap_q - 8'(tx_gap_q != 8'd0);
    rx_gap_d = rx_gap_q - 8'(rx_gap_q != 8'd0);
    tx_pend = (tx_full_q | tx_acc) & (tx_gap_q <= 8'd1);
    rx_pend = (~rx_valid_q | rx_rel) & (rx_gap_q <= 8'd1);
    sel_tx = tx_pend & (~rx_pend | ~last_tx_q);
    fail = (PREADY & PSLVERR) | abort;
    case (state_q)
      IDLE: if (tx_pend | rx_pend) begin
        state_d = SETUP;
        op_tx_d = sel_tx;
        last_tx_d = sel_tx;
        paddr_d = sel_tx ? 10'd2 : 10'd1;
        pwrite_d = 1'b0;
        pwdata_d = 32'd0;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (fail) begin
        state_d = IDLE;
        err_set = 1'b1;
        tx_full_d = op_tx_q ? 1'b0 : tx_full_d;
      end else if (PREADY && paddr_q != 10'd0) begin
        err_set = PRDATA[1];
        state_d = PRDATA[0] ? SETUP : IDLE;
        paddr_d = PRDATA[0] ? 10'd0 : paddr_q;
        pwrite_d = PRDATA[0] & op_tx_q;
        pwdata_d = (PRDATA[0] & op_tx_q) ? {24'd0, tx_data_q} : 32'd0;
        tx_gap_d = (!PRDATA[0] && op_tx_q) ? 8'(POLL_GAP) : tx_gap_d;
        rx_gap_d = (!PRDATA[0] && !op_tx_q) ? 8'(POLL_GAP) : rx_gap_d;
      end else if (PREADY) begin
        state_d = IDLE;
        tx_full_d = op_tx_q ? 1'b0 : tx_full_d;
        rx_valid_d = op_tx_q ? rx_valid_d : 1'b1;
        rx_data_d = op_tx_q ? rx_data_q : PRDATA[7:0];
      end
      default: state_d = IDLE;
    endcase
    err_d = err_set | (err_q & ~i_err_clr);
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state_q <= IDLE;
      paddr_q <= 10'd0;
      pwrite_q <= 1'b0;
      pwdata_q <= 32'd0;
      op_tx_q <= 1'b0;
      last_tx_q <= 1'b0;
      tx_full_q <= 1'b0;
      tx_data_q <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_data_q <= 8'd0;
      err_q <= 1'b0;
      tx_gap_q <= 8'd0;
      rx_gap_q <= 8'd0;
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      op_tx_q <= op_tx_d;
      last_tx_q <= last_tx_d;
      tx_full_q <= tx_full_d;
      tx_data_q <= tx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q <= rx_data_d;
      err_q <= err_d;
      tx_gap_q <= tx_gap_d;
      rx_gap_q <= rx_gap_d;
    end
endmodule
